// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one single-port, synchronous-read data RAM
// between the CPU datapath and a debug/host port. Each access takes 3 cycles.
module data_mem_arbiter #(
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  cpu_req_i,
  input  logic                  cpu_wr_i,
  input  logic [ADDR_BITS-1:0]  cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ack_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_c_o,
  output logic                  cpu_stall_c_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_wr_i,
  input  logic [ADDR_BITS-1:0]  dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_ack_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_c_o,
  output logic                  ram_wr_o,
  output logic [ADDR_BITS-1:0]  ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
  } op_t;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DBG = 1'b1;

  state_e state_q, state_d;
  op_t    op_q, op_d;
  logic   ram_wr_q, ram_wr_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   cpu_ack_q, cpu_ack_d;
  logic   dbg_ack_q, dbg_ack_d;
  logic   busy_q, busy_d;
  logic   grant_dbg;

  // Debug wins when it is the only requester, or on a tie after a CPU grant.
  assign grant_dbg = dbg_req_i && (!cpu_req_i || (last_q == SEL_CPU));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      ram_wr_q  <= 1'b0;
      owner_q   <= SEL_CPU;
      last_q    <= SEL_DBG;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ram_wr_q  <= ram_wr_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cpu_ack_q <= cpu_ack_d;
      dbg_ack_q <= dbg_ack_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ram_wr_d  = 1'b0;
    owner_d   = owner_q;
    last_d    = last_q;
    cpu_ack_d = 1'b0;
    dbg_ack_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i || dbg_req_i) begin
          owner_d  = grant_dbg;
          last_d   = grant_dbg;
          op_d     = grant_dbg ? op_t'{dbg_wr_i, dbg_addr_i, dbg_wdata_i}
                               : op_t'{cpu_wr_i, cpu_addr_i, cpu_wdata_i};
          ram_wr_d = grant_dbg ? dbg_wr_i : cpu_wr_i;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cpu_ack_d = (owner_q == SEL_CPU);
        dbg_ack_d = (owner_q == SEL_DBG);
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign dbg_ack_o   = dbg_ack_q;
  assign ram_wr_o    = ram_wr_q;
  assign ram_addr_o  = op_q.addr;
  assign ram_wdata_o = op_q.wdata;
  assign busy_o      = busy_q;

  // RAM read data only arrives in the ack cycle, so it is gated rather than re-registered.
  assign cpu_rdata_c_o = (cpu_ack_q && !op_q.wr) ? ram_rdata_i : '0;
  assign dbg_rdata_c_o = (dbg_ack_q && !op_q.wr) ? ram_rdata_i : '0;
  assign cpu_stall_c_o = cpu_req_i && !cpu_ack_q;

endmodule
